// File: rtl/caliptra_prim_onehot_enc_reg.sv
// Registered, valid/ready flow-controlled one-hot encoder with optional skid stage,
// out-of-range detection and a sticky self-check on the registered output.
module caliptra_prim_onehot_enc_reg #(
  parameter int  OneHotWidth = 32,
  parameter bit  SkidBuffer  = 1'b1,
  parameter bit  EnableCheck = 1'b1,
  localparam int InputWidth  = $clog2(OneHotWidth)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [InputWidth-1:0]  in_i,
  input  logic                   en_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [OneHotWidth-1:0] out_o,
  output logic                   oor_o,
  output logic                   oor_err_o,
  output logic                   chk_err_o,
  input  logic                   clr_err_i
);

  localparam bit Pow2 = (OneHotWidth == (1 << InputWidth));
  localparam int CntW = $clog2(OneHotWidth + 1);

  function automatic logic [OneHotWidth-1:0] encode(input logic [InputWidth-1:0] idx,
                                                    input logic en);
    logic [OneHotWidth-1:0] v;
    v = '0;
    for (int k = 0; k < OneHotWidth; k++) begin
      v[k] = en && (idx == InputWidth'(k));
    end
    return v;
  endfunction

  function automatic logic out_of_range(input logic [InputWidth-1:0] idx, input logic en);
    return !Pow2 && en && (32'(idx) >= $unsigned(OneHotWidth));
  endfunction

  function automatic logic is_onehot(input logic [OneHotWidth-1:0] v);
    logic [CntW-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < OneHotWidth; k++) begin
      cnt = cnt + CntW'(v[k]);
    end
    return cnt == CntW'(1);
  endfunction

  // An entry is consistent when a live, in-range encode holds exactly one bit and
  // every other state (empty, en=0, out-of-range) holds an all-zero vector.
  function automatic logic entry_bad(input logic vld, input logic en, input logic oor,
                                     input logic [OneHotWidth-1:0] vec);
    if (vld && en && !oor) begin
      return !is_onehot(vec);
    end else begin
      return vec != '0;
    end
  endfunction

  logic                   main_valid, main_en, main_oor;
  logic [OneHotWidth-1:0] main_vec;
  logic                   skid_valid, skid_en, skid_oor;
  logic [OneHotWidth-1:0] skid_vec;
  logic                   oor_err, chk_err;

  logic                   accept, emit, in_oor, chk_fail;
  logic [OneHotWidth-1:0] in_vec;

  assign ready_o = SkidBuffer ? !skid_valid : (!main_valid || ready_i);
  assign accept  = valid_i && ready_o;
  assign emit    = main_valid && ready_i;
  assign in_vec  = encode(in_i, en_i);
  assign in_oor  = out_of_range(in_i, en_i);

  // Self-check of both storage entries on registered state only.
  always_comb begin
    chk_fail = 1'b0;
    if (EnableCheck) begin
      chk_fail = entry_bad(main_valid, main_en, main_oor, main_vec) ||
                 entry_bad(skid_valid, skid_en, skid_oor, skid_vec);
    end else begin
      chk_fail = 1'b0;
    end
  end

  // Main/skid datapath. A beat only lands in skid when main is occupied and stalled,
  // which cannot happen without the skid stage because ready_o then implies emit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid <= 1'b0;
      main_en    <= 1'b0;
      main_oor   <= 1'b0;
      main_vec   <= '0;
      skid_valid <= 1'b0;
      skid_en    <= 1'b0;
      skid_oor   <= 1'b0;
      skid_vec   <= '0;
    end else if (emit && skid_valid) begin
      main_valid <= 1'b1;
      main_en    <= skid_en;
      main_oor   <= skid_oor;
      main_vec   <= skid_vec;
      skid_valid <= 1'b0;
      skid_en    <= 1'b0;
      skid_oor   <= 1'b0;
      skid_vec   <= '0;
    end else if (accept && (emit || !main_valid)) begin
      main_valid <= 1'b1;
      main_en    <= en_i;
      main_oor   <= in_oor;
      main_vec   <= in_vec;
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_en    <= en_i;
      skid_oor   <= in_oor;
      skid_vec   <= in_vec;
    end else if (emit) begin
      main_valid <= 1'b0;
      main_en    <= 1'b0;
      main_oor   <= 1'b0;
      main_vec   <= '0;
    end else begin
      main_valid <= main_valid;
      skid_valid <= skid_valid;
    end
  end

  // Sticky error flags; a new set in the clearing cycle takes priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oor_err <= 1'b0;
      chk_err <= 1'b0;
    end else begin
      oor_err <= (accept && in_oor) || (oor_err && !clr_err_i);
      chk_err <= chk_fail || (chk_err && !clr_err_i);
    end
  end

  assign valid_o   = main_valid;
  assign out_o     = main_valid ? main_vec : '0;
  assign oor_o     = main_valid && main_oor;
  assign oor_err_o = oor_err;
  assign chk_err_o = chk_err;

endmodule

// File: tb/tb_caliptra_prim_onehot_enc_reg.sv
// Bench: a 32-wide skid instance and a 5-wide no-skid instance, checked each cycle
// against a queue-based model plus directed literal expectations.
module tb_caliptra_prim_onehot_enc_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_valid_i, a_ready_o, a_en, a_valid_o, a_ready_i, a_oor, a_oor_err, a_chk_err, a_clr;
  logic [4:0]  a_in;
  logic [31:0] a_out;
  logic        b_valid_i, b_ready_o, b_en, b_valid_o, b_ready_i, b_oor, b_oor_err, b_chk_err, b_clr;
  logic [2:0]  b_in;
  logic [4:0]  b_out;

  caliptra_prim_onehot_enc_reg #(.OneHotWidth(32), .SkidBuffer(1'b1), .EnableCheck(1'b1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(a_valid_i), .ready_o(a_ready_o), .in_i(a_in),
    .en_i(a_en), .valid_o(a_valid_o), .ready_i(a_ready_i), .out_o(a_out), .oor_o(a_oor),
    .oor_err_o(a_oor_err), .chk_err_o(a_chk_err), .clr_err_i(a_clr));

  caliptra_prim_onehot_enc_reg #(.OneHotWidth(5), .SkidBuffer(1'b0), .EnableCheck(1'b1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(b_valid_i), .ready_o(b_ready_o), .in_i(b_in),
    .en_i(b_en), .valid_o(b_valid_o), .ready_i(b_ready_i), .out_o(b_out), .oor_o(b_oor),
    .oor_err_o(b_oor_err), .chk_err_o(b_chk_err), .clr_err_i(b_clr));

  int total = 0;
  int bad = 0;
  bit check_a = 1'b1;
  bit check_b = 1'b1;

  typedef struct { logic [31:0] vec; bit oor; } beat_t;
  beat_t qa[$];
  beat_t qb[$];
  bit ma_oor_err, mb_oor_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic beat_t make_beat(input int w, input int idx, input bit en);
    beat_t b;
    b.oor = en && (idx >= w);
    b.vec = (en && idx < w) ? (32'h1 << idx) : 32'h0;
    return b;
  endfunction

  // Reference model: FIFO of accepted beats; capacity 2 with skid, 1 (pass-through) without.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa.delete(); qb.delete();
      ma_oor_err = 1'b0; mb_oor_err = 1'b0;
    end else begin
      bit ra, rb, acc_a, acc_b;
      beat_t na, nb;
      ra = qa.size() < 2;
      rb = (qb.size() == 0) || b_ready_i;
      acc_a = a_valid_i && ra;
      acc_b = b_valid_i && rb;
      na = make_beat(32, int'(a_in), a_en);
      nb = make_beat(5, int'(b_in), b_en);
      if (qa.size() > 0 && a_ready_i) void'(qa.pop_front());
      if (qb.size() > 0 && b_ready_i) void'(qb.pop_front());
      if (acc_a) qa.push_back(na);
      if (acc_b) qb.push_back(nb);
      ma_oor_err = (acc_a && na.oor) || (ma_oor_err && !a_clr);
      mb_oor_err = (acc_b && nb.oor) || (mb_oor_err && !b_clr);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_a) begin
      check("a_valid", 32'(a_valid_o), 32'(qa.size() > 0));
      check("a_out", a_out, (qa.size() > 0) ? qa[0].vec : 32'h0);
      check("a_oor", 32'(a_oor), (qa.size() > 0) ? 32'(qa[0].oor) : 32'h0);
      check("a_ready", 32'(a_ready_o), 32'(qa.size() < 2));
      check("a_oor_err", 32'(a_oor_err), 32'(ma_oor_err));
      check("a_chk_err", 32'(a_chk_err), 32'h0);
    end
    if (check_b) begin
      check("b_valid", 32'(b_valid_o), 32'(qb.size() > 0));
      check("b_out", 32'(b_out), (qb.size() > 0) ? qb[0].vec : 32'h0);
      check("b_oor", 32'(b_oor), (qb.size() > 0) ? 32'(qb[0].oor) : 32'h0);
      check("b_ready", 32'(b_ready_o), 32'((qb.size() == 0) || b_ready_i));
      check("b_oor_err", 32'(b_oor_err), 32'(mb_oor_err));
      check("b_chk_err", 32'(b_chk_err), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_valid_i = 1'b0; a_in = 5'd0; a_en = 1'b0; a_ready_i = 1'b0; a_clr = 1'b0;
    b_valid_i = 1'b0; b_in = 3'd0; b_en = 1'b0; b_ready_i = 1'b0; b_clr = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(a_valid_o), 32'h0);
    check("rst_out", a_out, 32'h0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(a_ready_o), 32'h1);

    // Basic encode of 5
    tick(); a_valid_i = 1'b1; a_in = 5'd5; a_en = 1'b1; a_ready_i = 1'b1;
    tick(); a_valid_i = 1'b0;
    @(negedge clk);
    check("basic_valid", 32'(a_valid_o), 32'h1);
    check("basic_out", a_out, 32'h0000_0020);

    // Back-to-back streaming 0..31
    for (int i = 0; i <= 32; i++) begin
      tick();
      if (i < 32) begin a_valid_i = 1'b1; a_in = 5'(i); end
      else a_valid_i = 1'b0;
      @(negedge clk);
      if (i > 0) begin
        check("stream_valid", 32'(a_valid_o), 32'h1);
        check("stream_out", a_out, 32'h1 << (i - 1));
      end
    end

    // Backpressure through the skid stage
    tick(); a_ready_i = 1'b0; a_valid_i = 1'b1; a_in = 5'd3;
    tick(); a_in = 5'd7;
    tick(); a_in = 5'd9;
    @(negedge clk);
    check("bp_ready_drop", 32'(a_ready_o), 32'h0);
    check("bp_hold", a_out, 32'h8);
    tick();
    @(negedge clk);
    check("bp_hold2", a_out, 32'h8);
    tick(); a_ready_i = 1'b1;
    @(negedge clk);
    check("bp_out0", a_out, 32'h8);
    tick();
    @(negedge clk);
    check("bp_out1", a_out, 32'h80);
    check("bp_ready_back", 32'(a_ready_o), 32'h1);
    tick(); a_valid_i = 1'b0;
    @(negedge clk);
    check("bp_out2", a_out, 32'h200);
    tick();
    @(negedge clk);
    check("bp_drained", 32'(a_valid_o), 32'h0);

    // en_i=0 beat on the 5-wide instance
    tick(); b_ready_i = 1'b1; b_valid_i = 1'b1; b_en = 1'b0; b_in = 3'd2;
    tick(); b_valid_i = 1'b0;
    @(negedge clk);
    check("en0_valid", 32'(b_valid_o), 32'h1);
    check("en0_out", 32'(b_out), 32'h0);
    check("en0_chk", 32'(b_chk_err), 32'h0);

    // Out-of-range index 6, then in-range 4
    tick(); b_valid_i = 1'b1; b_en = 1'b1; b_in = 3'd6;
    tick(); b_in = 3'd4;
    @(negedge clk);
    check("oor_out", 32'(b_out), 32'h0);
    check("oor_flag", 32'(b_oor), 32'h1);
    check("oor_err", 32'(b_oor_err), 32'h1);
    tick(); b_valid_i = 1'b0;
    @(negedge clk);
    check("inrange_out", 32'(b_out), 32'h10);
    check("inrange_oor", 32'(b_oor), 32'h0);
    check("oor_err_sticky", 32'(b_oor_err), 32'h1);

    // Clear coinciding with a new oor accept, then clear alone
    tick(); b_valid_i = 1'b1; b_in = 3'd7; b_clr = 1'b1;
    tick(); b_valid_i = 1'b0; b_clr = 1'b0;
    @(negedge clk);
    check("set_beats_clr", 32'(b_oor_err), 32'h1);
    tick(); b_clr = 1'b1;
    tick(); b_clr = 1'b0;
    @(negedge clk);
    check("clr_alone", 32'(b_oor_err), 32'h0);

    // Corrupt the held main entry of the 32-wide instance
    tick(); a_ready_i = 1'b0; a_valid_i = 1'b1; a_in = 5'd4; a_en = 1'b1;
    tick(); a_valid_i = 1'b0;
    @(negedge clk);
    check("pre_force_out", a_out, 32'h10);
    check_a = 1'b0;
    force dut_a.main_vec = 32'h3;
    tick();
    @(negedge clk);
    check("chk_err_set", 32'(a_chk_err), 32'h1);
    release dut_a.main_vec;
    a_ready_i = 1'b1;
    tick();
    tick(); a_clr = 1'b1;
    tick(); a_clr = 1'b0;
    @(negedge clk);
    check("chk_err_clr", 32'(a_chk_err), 32'h0);
    check("chk_oor_err_clr", 32'(a_oor_err), 32'h0);
    check("chk_drained", 32'(a_valid_o), 32'h0);
    check_a = 1'b1;

    // Reset with main and skid full, plus a pending oor error
    tick(); a_ready_i = 1'b0; a_valid_i = 1'b1; a_in = 5'd1;
    b_valid_i = 1'b1; b_in = 3'd6;
    tick(); a_in = 5'd2; b_valid_i = 1'b0;
    tick(); a_valid_i = 1'b0;
    @(negedge clk);
    check("full_ready", 32'(a_ready_o), 32'h0);
    check("pre_rst_err", 32'(b_oor_err), 32'h1);
    tick(); rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(a_valid_o), 32'h0);
    check("mid_rst_out", a_out, 32'h0);
    check("mid_rst_err", 32'(b_oor_err), 32'h0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(a_ready_o), 32'h1);
    check("post_rst_valid", 32'(a_valid_o), 32'h0);

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/caliptra_prim_onehot_enc_reg.md
Name: caliptra_prim_onehot_enc_reg

Overview:
Registered, flow-controlled one-hot encoder. It converts a binary index into a one-hot vector behind a valid/ready handshake, with an optional skid buffer for full throughput. It flags out-of-range indices for non-power-of-two widths and continuously self-checks the registered output, raising sticky error flags. It is used where a decoded select must cross a pipeline boundary, such as a mux-select or grant fan-out feeding hardened logic.

Parameters:
OneHotWidth, 32, number of one-hot output bits; must be >= 2; need not be a power of two.
SkidBuffer, 1, 1 = 2-entry (main + skid) output stage with registered ready_o; 0 = single output register with combinational ready_o.
EnableCheck, 1, 1 = output self-check logic instantiated; 0 = chk_err_o tied 0.
InputWidth (localparam), $clog2(OneHotWidth), width of the binary index.

Ports:
clk_i  input  1  clock; all state on rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  input beat valid
ready_o  output  1  block can accept a beat
in_i  input  InputWidth  binary index
en_i  input  1  1 = encode in_i; 0 = beat carries all-zero vector
valid_o  output  1  output beat valid
ready_i  input  1  downstream accepts output beat
out_o  output  OneHotWidth  one-hot vector of the head beat; 0 when valid_o=0
oor_o  output  1  head beat had en_i=1 with in_i >= OneHotWidth (qualified by valid_o)
oor_err_o  output  1  sticky: any out-of-range beat accepted
chk_err_o  output  1  sticky: registered output failed self-check
clr_err_i  input  1  clears both sticky error flags

Behaviour:
- Reset (async assert, sync deassert handled upstream): valid_o=0, out_o=0, oor_o=0, oor_err_o=0, chk_err_o=0. ready_o=1 once reset deasserts. Any in-flight beats are discarded.
- Accept: a beat is accepted when valid_i && ready_o. Emit: a beat is emitted when valid_o && ready_i.
- Encode at accept: bit k = en_i && (in_i == k) for k < OneHotWidth. If en_i=1 and in_i >= OneHotWidth, the vector is all zero and the stored oor flag is 1.
- Latency: an accepted beat appears on out_o in the next cycle. No combinational path from in_i to out_o.
- SkidBuffer=0:
  - ready_o = !valid_o || ready_i.
  - Accept and emit in the same cycle sustains 1 beat/cycle.
- SkidBuffer=1:
  - ready_o = !skid_valid_q, registered.
  - If a beat is accepted while main is valid and ready_i=0, it goes to skid.
  - On emit, skid moves to main.
  - Sustains 1 beat/cycle.
  - Order is strictly FIFO; no beat is dropped or duplicated.
- Hold: while valid_o && !ready_i, out_o and oor_o are stable.
- out_o is forced to 0 when valid_o=0 (the main register is cleared on emit without refill).
- oor_err_o: set on accept of an oor beat. chk_err_o: set in any cycle the check fails. clr_err_i clears both. If set and clear happen in the same cycle, set wins.
- Self-check (EnableCheck=1), evaluated every cycle on registered state:
  - valid && en && !oor requires popcount(out)=1.
  - Otherwise it requires out=0.
  - It stores en per entry for this check.
- Power-of-two OneHotWidth: oor is unreachable. oor_o and oor_err_o stay 0.
- valid_i without ready_o: upstream holds the beat. The block samples nothing.

Test Plan:
- Reset: assert rst_ni=0 mid-stream with main and skid full -> next cycle valid_o=0, out_o=0, both errors 0, ready_o=1 after release.
- Basic, OneHotWidth=32: in_i=5, en_i=1, ready_i=1 -> 1 cycle later valid_o=1, out_o=32'h0000_0020. Streaming 0..31 back-to-back yields 32 consecutive beats, no bubbles.
- Backpressure, SkidBuffer=1: send 3,7,9 with ready_i=0 -> ready_o drops after 2 beats and out_o holds 0x8. Release ready_i -> outputs 0x8, 0x80, 0x200 in order.
- Out-of-range, OneHotWidth=5: in_i=6, en_i=1 -> out_o=5'b00000, oor_o=1, oor_err_o=1 sticky. in_i=4 -> 5'b10000, oor_o=0.
- en_i=0: in_i=2 -> valid_o=1, out_o=0, oor_o=0, chk_err_o stays 0.
- Errors: force the main register to 0x3 on a valid en beat -> chk_err_o=1. Apply clr_err_i in the same cycle as a new oor accept -> oor_err_o remains 1; clr_err_i alone -> both 0.
